// File: rtl/disk_sector_server_if.sv
// Signal bundle between the sector server, the floppy disk controller (FDC)
// and the byte-wide disk image memory.
interface disk_sector_server_if;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out;
  logic        disk_data_clkout;
  logic [1:0]  img_present;
  logic [20:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  // Environment side: FDC plus image memory.
  modport master (
    output disk_sr, disk_data_out, img_present, mem_rdata, mem_ack,
    input  disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  // Server side.
  modport slave (
    input  disk_sr, disk_data_out, img_present, mem_rdata, mem_ack,
    output disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/disk_sector_server.sv
// Disk sector server: moves one 512-byte sector between the FDC byte stream
// and the disk image memory, one memory access per byte, strobes paced.
module disk_sector_server #(
  parameter int TRACKS  = 80,
  parameter int SECTORS = 10,
  parameter int PACE    = 4
) (
  input  logic                  clk24,
  input  logic                  rstn,
  disk_sector_server_if.slave   bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_RD_MEM  = 3'd2;
  localparam logic [2:0] S_RD_PUSH = 3'd3;
  localparam logic [2:0] S_WR_PULL = 3'd4;
  localparam logic [2:0] S_WR_MEM  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [7:0] PACE_M1   = 8'(PACE - 1);
  localparam logic [7:0] TRACKS_L  = 8'(TRACKS);
  localparam logic [5:0] SECTORS_L = 6'(SECTORS);
  localparam logic [8:0] LAST_IDX  = 9'd511;

  logic [2:0]  state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic        side_q, side_d;
  logic        drive_q, drive_d;
  logic [6:0]  track_q, track_d;
  logic [4:0]  sector_q, sector_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  since_q, since_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        clkin_q, clkin_d;
  logic        clkout_q, clkout_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  img_q;

  logic [15:0] lin_sector;
  logic        req_live;
  logic        pace_ok;
  logic        bad_req;
  logic        unused_bits;

  // Linear sector number within one drive image; the byte offset is this
  // times 512, so the index simply fills the low 9 address bits.
  assign lin_sector = (16'(track_q) * 16'd2 + 16'(side_q)) * 16'(SECTORS)
                      + 16'(sector_q) - 16'd1;
  assign req_live   = is_wr_q ? bus.disk_sr[1] : bus.disk_sr[0];
  assign pace_ok    = (since_q >= PACE_M1);
  assign bad_req    = ({1'b0, track_q} >= TRACKS_L)
                    || (sector_q == 5'd0)
                    || ({1'b0, sector_q} > SECTORS_L)
                    || !bus.img_present[drive_q]
                    || (bus.disk_sr[1:0] == 2'b11);
  assign unused_bits = ^{bus.disk_sr[31:21], bus.disk_sr[15], bus.disk_sr[7:4],
                         lin_sector[15:11]};

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    side_d    = side_q;
    drive_d   = drive_q;
    track_d   = track_q;
    sector_d  = sector_q;
    idx_d     = idx_q;
    since_d   = pace_ok ? since_q : since_q + 8'd1;
    data_in_d = data_in_q;
    clkin_d   = 1'b0;
    clkout_d  = 1'b0;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        idx_d = 9'd0;
        if (bus.disk_sr[0] ^ bus.disk_sr[1]) begin
          state_d  = S_CHECK;
          is_wr_d  = bus.disk_sr[1];
          side_d   = bus.disk_sr[2];
          drive_d  = bus.disk_sr[3];
          track_d  = bus.disk_sr[14:8];
          sector_d = bus.disk_sr[20:16];
        end
      end
      S_CHECK: begin
        if (bad_req) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (is_wr_q) begin
          state_d = S_WR_PULL;
        end else begin
          state_d  = S_RD_MEM;
          mem_rd_d = 1'b1;
          addr_d   = {drive_q, lin_sector[10:0], idx_d};
        end
      end
      S_RD_MEM: begin
        if (bus.mem_ack) begin
          mem_rd_d  = 1'b0;
          data_in_d = bus.mem_rdata;
          state_d   = req_live ? S_RD_PUSH : S_IDLE;
        end
      end
      S_RD_PUSH: begin
        if (!req_live) begin
          state_d = S_IDLE;
        end else if (pace_ok) begin
          clkin_d = 1'b1;
          since_d = 8'd0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_q + 9'd1;
            state_d  = S_RD_MEM;
            mem_rd_d = 1'b1;
            addr_d   = {drive_q, lin_sector[10:0], idx_d};
          end
        end
      end
      S_WR_PULL: begin
        // The FDC byte is valid during the strobe cycle, so it is captured
        // on the edge that ends the strobe, even if the request just fell.
        if (clkout_q) begin
          wdata_d  = bus.disk_data_out;
          mem_wr_d = 1'b1;
          addr_d   = {drive_q, lin_sector[10:0], idx_q};
          state_d  = S_WR_MEM;
        end else if (!req_live) begin
          state_d = S_IDLE;
        end else if (pace_ok) begin
          clkout_d = 1'b1;
          since_d  = 8'd0;
        end
      end
      S_WR_MEM: begin
        if (bus.mem_ack) begin
          mem_wr_d = 1'b0;
          if (!req_live) begin
            state_d = S_IDLE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = S_WR_PULL;
          end
        end
      end
      S_DONE: begin
        if (!req_live) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      S_ERR: begin
        if (bus.disk_sr[1:0] == 2'b00) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk24 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      side_q    <= 1'b0;
      drive_q   <= 1'b0;
      track_q   <= 7'd0;
      sector_q  <= 5'd0;
      idx_q     <= 9'd0;
      since_q   <= PACE_M1;
      data_in_q <= 8'd0;
      clkin_q   <= 1'b0;
      clkout_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      addr_q    <= 21'd0;
      wdata_q   <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      img_q     <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      side_q    <= side_d;
      drive_q   <= drive_d;
      track_q   <= track_d;
      sector_q  <= sector_d;
      idx_q     <= idx_d;
      since_q   <= since_d;
      data_in_q <= data_in_d;
      clkin_q   <= clkin_d;
      clkout_q  <= clkout_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      img_q     <= bus.img_present;
    end
  end

  assign bus.disk_cr          = {28'd0, img_q, err_q, done_q};
  assign bus.disk_data_in     = data_in_q;
  assign bus.disk_data_clkin  = clkin_q;
  assign bus.disk_data_clkout = clkout_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_rd           = mem_rd_q;
  assign bus.mem_wr           = mem_wr_q;
  assign bus.mem_wdata        = wdata_q;
endmodule

// File: tb/tb_disk_sector_server.sv
// Directed bench for disk_sector_server: memory and FDC models with a
// scoreboard of expected addresses and bytes.
module tb_disk_sector_server;
  localparam int TB_PACE    = 2;
  localparam int TB_SECTORS = 10;

  logic clk24 = 1'b0;
  logic rstn;

  disk_sector_server_if bus ();

  disk_sector_server #(.TRACKS(80), .SECTORS(TB_SECTORS), .PACE(TB_PACE)) dut (
    .clk24 (clk24),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 clk24 = ~clk24;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [20:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [7:0]  exp_data_q[$];

  int cyc = 0;
  int ack_dly = 1;
  int wait_cnt = 0;
  int acc_cnt = 0;
  int clkin_cnt = 0;
  int clkout_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int min_gap = 1000;
  int last_strobe = -1000;
  int wr_base = 0;
  bit wr_const = 1'b1;
  int in_base, out_base, acc_base, done_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] img_addr(input int drv, input int trk, input int side,
                                           input int sec, input int i);
    int off;
    off = ((trk * 2 + side) * TB_SECTORS + sec - 1) * 512 + i;
    return 21'(drv * 1048576 + off);
  endfunction

  function automatic logic [31:0] make_sr(input bit rd, input bit wr, input int side,
                                          input int drv, input int trk, input int sec);
    logic [31:0] s;
    s        = '0;
    s[0]     = rd;
    s[1]     = wr;
    s[2]     = side[0];
    s[3]     = drv[0];
    s[14:8]  = trk[6:0];
    s[20:16] = sec[4:0];
    return s;
  endfunction

  always @(posedge clk24) cyc++;

  // Image memory: acks each request after ack_dly cycles; content is a hash of the address.
  always @(negedge clk24) begin
    logic ack_n;
    logic [20:0] a;
    ack_n = 1'b0;
    if (bus.mem_ack !== 1'b1 && (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1)) begin
      wait_cnt++;
      if (wait_cnt >= ack_dly) begin
        wait_cnt = 0;
        ack_n = 1'b1;
        a = bus.mem_addr;
        bus.mem_rdata = a[7:0] ^ a[16:9];
        acc_cnt++;
        if (exp_addr_q.size() == 0) check("mem_addr_q_empty", exp_addr_q.size(), 1);
        else check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
        if (bus.mem_wr === 1'b1) begin
          if (exp_data_q.size() == 0) check("wr_data_q_empty", exp_data_q.size(), 1);
          else check("wr_data", bus.mem_wdata, exp_data_q.pop_front());
        end
      end
    end else begin
      wait_cnt = 0;
    end
    bus.mem_ack = ack_n;
  end

  // FDC side: checks delivered bytes, supplies written bytes, tracks strobe spacing.
  always @(negedge clk24) begin
    if (bus.disk_cr[0] === 1'b1) done_cnt++;
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) overlap_cnt++;
    if (bus.disk_data_clkin === 1'b1 || bus.disk_data_clkout === 1'b1) begin
      if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
    end
    if (bus.disk_data_clkin === 1'b1) begin
      clkin_cnt++;
      if (exp_byte_q.size() == 0) check("rd_byte_q_empty", exp_byte_q.size(), 1);
      else check("rd_byte", bus.disk_data_in, exp_byte_q.pop_front());
    end
    bus.disk_data_out = wr_const ? 8'hA5 : (8'(clkout_cnt - wr_base) ^ 8'h3C);
    if (bus.disk_data_clkout === 1'b1) clkout_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk24);
  endtask

  task automatic flush();
    exp_addr_q.delete();
    exp_byte_q.delete();
    exp_data_q.delete();
  endtask

  task automatic start_xfer(input bit wr, input int drv, input int trk, input int side,
                            input int sec, input bit cnst);
    logic [20:0] a;
    for (int i = 0; i < 512; i++) begin
      a = img_addr(drv, trk, side, sec, i);
      exp_addr_q.push_back(a);
      if (wr) exp_data_q.push_back(cnst ? 8'hA5 : (8'(i) ^ 8'h3C));
      else    exp_byte_q.push_back(a[7:0] ^ a[16:9]);
    end
    in_base   = clkin_cnt;
    out_base  = clkout_cnt;
    acc_base  = acc_cnt;
    done_base = done_cnt;
    wr_base   = clkout_cnt;
    wr_const  = cnst;
    bus.disk_sr = make_sr(!wr, wr, side, drv, trk, sec);
  endtask

  task automatic finish_xfer(input string tag, input bit wr);
    int k;
    k = 0;
    while (bus.disk_cr[0] !== 1'b1 && k < 20000) begin
      @(negedge clk24);
      k++;
    end
    check({tag, "_done"}, bus.disk_cr[0], 1);
    @(negedge clk24);
    check({tag, "_strobes"}, wr ? clkout_cnt - out_base : clkin_cnt - in_base, 512);
    check({tag, "_mem_acc"}, acc_cnt - acc_base, 512);
    check({tag, "_cr"}, bus.disk_cr[1:0], 2'b01);
    check({tag, "_sb_left"}, exp_addr_q.size() + exp_byte_q.size() + exp_data_q.size(), 0);
    bus.disk_sr = '0;
    wait_cycles(2);
    check({tag, "_clear"}, bus.disk_cr[1:0], 2'b00);
  endtask

  int e_trk[4] = '{0, 0, 80, 5};
  int e_sec[4] = '{11, 0, 1, 2};
  logic [1:0] e_img[4] = '{2'b11, 2'b11, 2'b11, 2'b10};

  initial begin
    int k;
    rstn = 1'b0;
    bus.disk_sr = '0;
    bus.img_present = 2'b11;
    wait_cycles(3);

    // Reset state.
    check("rst_cr", bus.disk_cr, 0);
    check("rst_clkin", bus.disk_data_clkin, 0);
    check("rst_clkout", bus.disk_data_clkout, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // Request already present at reset release; drive 1, track 0, side 0, sector 1.
    start_xfer(1'b0, 0, 0, 0, 1, 1'b1);
    rstn = 1'b1;
    wait_cycles(2);
    check("first_edge_mem_rd", bus.mem_rd, 1);
    check("first_edge_addr", bus.mem_addr, 0);
    check("img_bits", bus.disk_cr[3:2], 2'b11);
    finish_xfer("rd_d1_t0_s1", 1'b0);

    // Write, drive 2, track 79, side 1, sector 10, constant 0xA5.
    start_xfer(1'b1, 1, 79, 1, 10, 1'b1);
    finish_xfer("wr_d2_t79_s10", 1'b1);

    // Rejected requests: sector 11, sector 0, track 80, missing image.
    for (int i = 0; i < 4; i++) begin
      bus.img_present = e_img[i];
      wait_cycles(2);
      acc_base = acc_cnt;
      bus.disk_sr = make_sr(1'b1, 1'b0, 0, 0, e_trk[i], e_sec[i]);
      wait_cycles(2);
      check("err_within_2", bus.disk_cr[1:0], 2'b11);
      wait_cycles(6);
      check("err_held", bus.disk_cr[1:0], 2'b11);
      check("err_no_mem", acc_cnt - acc_base, 0);
      check("err_img_bits", bus.disk_cr[3:2], e_img[i]);
      bus.disk_sr = '0;
      wait_cycles(2);
      check("err_clear", bus.disk_cr[1:0], 2'b00);
    end
    bus.img_present = 2'b11;
    wait_cycles(2);

    // Abort after 100 bytes, then restart the same sector from byte 0.
    start_xfer(1'b0, 1, 10, 0, 4, 1'b1);
    k = 0;
    while (clkin_cnt - in_base < 100 && k < 5000) begin
      @(negedge clk24);
      k++;
    end
    check("abort_reached_100", clkin_cnt - in_base >= 100, 1);
    bus.disk_sr = '0;
    wait_cycles(20);
    check("abort_strobes", clkin_cnt - in_base, 100);
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_cr", bus.disk_cr[1:0], 2'b00);
    check("abort_mem_idle", {bus.mem_rd, bus.mem_wr}, 2'b00);
    flush();
    start_xfer(1'b0, 1, 10, 0, 4, 1'b1);
    finish_xfer("rd_restart", 1'b0);

    // Asynchronous reset while mem_wr is held.
    ack_dly = 7;
    start_xfer(1'b1, 0, 2, 0, 3, 1'b0);
    k = 0;
    while (!(acc_cnt - acc_base >= 20 && bus.mem_wr === 1'b1) && k < 5000) begin
      @(negedge clk24);
      k++;
    end
    check("rst_mid_reached", bus.mem_wr, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_cr", bus.disk_cr, 0);
    check("arst_data_in", bus.disk_data_in, 0);
    check("arst_clkin", bus.disk_data_clkin, 0);
    check("arst_clkout", bus.disk_data_clkout, 0);
    check("arst_mem_rd", bus.mem_rd, 0);
    check("arst_mem_wr", bus.mem_wr, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    bus.disk_sr = '0;
    flush();
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(2);

    // Slow memory (7-cycle ack): read then patterned write.
    start_xfer(1'b0, 1, 40, 1, 6, 1'b1);
    finish_xfer("rd_slow", 1'b0);
    start_xfer(1'b1, 0, 0, 1, 10, 1'b0);
    finish_xfer("wr_slow_pattern", 1'b1);

    check("min_strobe_gap_ok", min_gap >= TB_PACE, 1);
    check("rd_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
